rob_read_arbiter: RTL and testbench

- Shares the AR/R slave port of reorder_buffer between two upstream read requesters.
- Round-robin arbitration on AR with a registered output stage.
- Tags each downstream ID with the requester index and routes R beats back by that tag.
- Per-requester outstanding-transaction counters throttle each requester so neither can monopolise the reorder buffer slots.

---
 rtl/rob_read_arbiter.sv | 127 ++++++++++++
 tb/tb_rob_read_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_read_arbiter.sv
// Two-requester read arbiter in front of the reorder_buffer AR/R slave port.
// Round-robin AR grant into a registered AR stage, ID tagging, R routing by tag, per-requester throttling.
module rob_read_arbiter #(
  parameter int DATA_WIDTH      = 8,
  parameter int ID_WIDTH        = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s0_arid_i,
  input  logic                  s0_arvalid_i,
  output logic                  s0_arready_o,
  output logic [DATA_WIDTH-1:0] s0_rdata_o,
  output logic [ID_WIDTH-1:0]   s0_rid_o,
  output logic                  s0_rvalid_o,
  input  logic                  s0_rready_i,
  input  logic [ID_WIDTH-1:0]   s1_arid_i,
  input  logic                  s1_arvalid_i,
  output logic                  s1_arready_o,
  output logic [DATA_WIDTH-1:0] s1_rdata_o,
  output logic [ID_WIDTH-1:0]   s1_rid_o,
  output logic                  s1_rvalid_o,
  input  logic                  s1_rready_i,
  output logic [ID_WIDTH:0]     m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [ID_WIDTH:0]     m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);

  // Handshakes are valid/ready: a transfer happens on a rising clk edge where both are high;
  // a held valid keeps its payload stable until ready.
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic                m_arvalid_q, m_arvalid_d;
  logic [ID_WIDTH:0]   m_arid_q, m_arid_d;
  logic                last_grant_q, last_grant_d;
  logic [3:0]          cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                slot_free, elig0, elig1, grant0, grant1;
  logic                accept0, accept1, r_sel, r_hs0, r_hs1;

  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0) res = cnt - 4'd1;
    return res;
  endfunction

  assign slot_free = !m_arvalid_q || m_arready_i;
  assign elig0     = s0_arvalid_i && (cnt0_q < MAX_CNT);
  assign elig1     = s1_arvalid_i && (cnt1_q < MAX_CNT);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign s0_arready_o = grant0;
  assign s1_arready_o = grant1;
  assign accept0      = s0_arvalid_i && s0_arready_o;
  assign accept1      = s1_arvalid_i && s1_arready_o;

  always_comb begin
    m_arvalid_d  = m_arvalid_q;
    m_arid_d     = m_arid_q;
    last_grant_d = last_grant_q;
    if (accept0) begin
      m_arvalid_d  = 1'b1;
      m_arid_d     = {1'b0, s0_arid_i};
      last_grant_d = 1'b0;
    end else if (accept1) begin
      m_arvalid_d  = 1'b1;
      m_arid_d     = {1'b1, s1_arid_i};
      last_grant_d = 1'b1;
    end else if (m_arready_i) begin
      m_arvalid_d  = 1'b0;
    end
  end

  // R path is purely combinational; the tag bit selects the requester.
  assign r_sel       = m_rid_i[ID_WIDTH];
  assign s0_rvalid_o = m_rvalid_i && !r_sel;
  assign s1_rvalid_o = m_rvalid_i && r_sel;
  assign m_rready_o  = r_sel ? s1_rready_i : s0_rready_i;
  assign s0_rdata_o  = m_rdata_i;
  assign s1_rdata_o  = m_rdata_i;
  assign s0_rid_o    = m_rid_i[ID_WIDTH-1:0];
  assign s1_rid_o    = m_rid_i[ID_WIDTH-1:0];
  assign r_hs0       = s0_rvalid_o && s0_rready_i;
  assign r_hs1       = s1_rvalid_o && s1_rready_i;

  assign cnt0_d = cnt_next(cnt0_q, accept0, r_hs0);
  assign cnt1_d = cnt_next(cnt1_q, accept1, r_hs1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid_q  <= 1'b0;
      m_arid_q     <= '0;
      last_grant_q <= 1'b1;
      cnt0_q       <= 4'd0;
      cnt1_q       <= 4'd0;
    end else begin
      m_arvalid_q  <= m_arvalid_d;
      m_arid_q     <= m_arid_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m_arvalid_o = m_arvalid_q;
  assign m_arid_o    = m_arid_q;

endmodule

// File: tb/tb_rob_read_arbiter.sv
// Bench for rob_read_arbiter: directed scenarios then random traffic, checked by a
// reference model plus an AR scoreboard queue popped by a separate monitor.
module tb_rob_read_arbiter;
  localparam int DW   = 8;
  localparam int IW   = 3;
  localparam int MAXO = 4;

  logic          clk, rst_n;
  logic [IW-1:0] s0_arid_i, s1_arid_i, s0_rid_o, s1_rid_o;
  logic          s0_arvalid_i, s1_arvalid_i, s0_arready_o, s1_arready_o;
  logic [DW-1:0] s0_rdata_o, s1_rdata_o, m_rdata_i;
  logic          s0_rvalid_o, s1_rvalid_o, s0_rready_i, s1_rready_i;
  logic [IW:0]   m_arid_o, m_rid_i;
  logic          m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW:0] exp_q[$];
  logic [IW:0] infl[$];

  int   outst[2];
  int   last_win;
  bit   pend;

  rob_read_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arid_i(s0_arid_i), .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o),
    .s0_rdata_o(s0_rdata_o), .s0_rid_o(s0_rid_o), .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
    .s1_arid_i(s1_arid_i), .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o),
    .s1_rdata_o(s1_rdata_o), .s1_rid_o(s1_rid_o), .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: arbitration, throttling and R routing from the rules, sampled at negedge
  always @(negedge clk) begin
    int  g;
    bit  free, e0, e1, sel, exp_rr;
    if (!rst_n) begin
      outst[0] = 0; outst[1] = 0; last_win = 1; pend = 1'b0;
      exp_q.delete(); infl.delete();
    end else begin
      free = !pend || m_arready_i;
      e0 = s0_arvalid_i && outst[0] < MAXO;
      e1 = s1_arvalid_i && outst[1] < MAXO;
      g = -1;
      if (free) begin
        if (e0 && e1) g = (last_win == 1) ? 0 : 1;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
      end
      chk("s0_arready", 32'(s0_arready_o), 32'(g == 0));
      chk("s1_arready", 32'(s1_arready_o), 32'(g == 1));
      chk("m_arvalid", 32'(m_arvalid_o), 32'(pend));
      sel    = m_rid_i[IW];
      exp_rr = sel ? s1_rready_i : s0_rready_i;
      chk("s0_rvalid", 32'(s0_rvalid_o), 32'(m_rvalid_i && !sel));
      chk("s1_rvalid", 32'(s1_rvalid_o), 32'(m_rvalid_i && sel));
      chk("m_rready", 32'(m_rready_o), 32'(exp_rr));
      if (m_rvalid_i) begin
        chk("r_data", 32'(sel ? s1_rdata_o : s0_rdata_o), 32'(m_rdata_i));
        chk("r_id", 32'(sel ? s1_rid_o : s0_rid_o), 32'(m_rid_i[IW-1:0]));
      end
      if (m_rvalid_i && exp_rr && outst[sel] > 0) outst[sel]--;
      if (g >= 0) begin
        exp_q.push_back({g == 1, (g == 1) ? s1_arid_i : s0_arid_i});
        last_win = g;
        outst[g]++;
        pend = 1'b1;
      end else if (m_arready_i) begin
        pend = 1'b0;
      end
    end
  end

  // monitor: every presented downstream AR must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && m_arvalid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL m_ar_unexpected: got %0h expected none", m_arid_o);
      end else begin
        chk("m_arid", 32'(m_arid_o), 32'(exp_q[0]));
        if (m_arready_i) begin
          infl.push_back(exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic idle();
    s0_arvalid_i = 0; s1_arvalid_i = 0; s0_arid_i = 0; s1_arid_i = 0;
    m_arready_i = 1; m_rvalid_i = 0; m_rid_i = 0; m_rdata_i = 0;
    s0_rready_i = 1; s1_rready_i = 1;
  endtask

  task automatic tick();
    bit hs;
    hs = rst_n && m_rvalid_i && (m_rid_i[IW] ? s1_rready_i : s0_rready_i);
    @(posedge clk);
    if (hs) begin
      for (int i = 0; i < infl.size(); i++) begin
        if (infl[i] == m_rid_i) begin
          infl.delete(i);
          break;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst_arvalid", 32'(m_arvalid_o), 32'd0);
    chk("rst_arid", 32'(m_arid_o), 32'd0);
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic issue0(input logic [IW-1:0] id, input bit exp_rdy);
    s0_arvalid_i = 1; s0_arid_i = id;
    #1;
    chk("issue0_ready", 32'(s0_arready_o), 32'(exp_rdy));
    tick();
  endtask

  logic [IW:0] seq[4];

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("reset_arvalid", 32'(m_arvalid_o), 32'd0);
    chk("reset_arid", 32'(m_arid_o), 32'd0);
    chk("reset_arready0", 32'(s0_arready_o), 32'd0);
    rst_n = 1;
    tick();

    // single request
    issue0(3'd2, 1'b1);
    s0_arvalid_i = 0;
    chk("single_arvalid", 32'(m_arvalid_o), 32'd1);
    chk("single_arid", 32'(m_arid_o), 32'h2);
    tick();

    // contention: requester 0 first after reset, then alternate
    do_reset();
    seq[0] = 4'h3; seq[1] = 4'hD; seq[2] = 4'h3; seq[3] = 4'hD;
    s0_arvalid_i = 1; s0_arid_i = 3'd3; s1_arvalid_i = 1; s1_arid_i = 3'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contend_arid", 32'(m_arid_o), 32'(seq[k]));
    end
    idle(); tick(); tick();

    // backpressure hold then drain+accept in one cycle
    do_reset();
    s1_arvalid_i = 1; s1_arid_i = 3'd5; m_arready_i = 0;
    #1; chk("bp_first_ready", 32'(s1_arready_o), 32'd1);
    tick();
    s1_arvalid_i = 0; s0_arvalid_i = 1; s0_arid_i = 3'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_arid", 32'(m_arid_o), 32'hD);
      chk("bp_hold_arvalid", 32'(m_arvalid_o), 32'd1);
      chk("bp_hold_rdy0", 32'(s0_arready_o), 32'd0);
      chk("bp_hold_rdy1", 32'(s1_arready_o), 32'd0);
      tick();
    end
    m_arready_i = 1;
    #1; chk("bp_release_rdy0", 32'(s0_arready_o), 32'd1);
    tick();
    s0_arvalid_i = 0;
    chk("bp_next_arid", 32'(m_arid_o), 32'h3);
    tick();

    // R routing to requester 1
    m_rvalid_i = 1; m_rid_i = 4'hD; m_rdata_i = 8'h70;
    #1;
    chk("r_s1_rvalid", 32'(s1_rvalid_o), 32'd1);
    chk("r_s1_rid", 32'(s1_rid_o), 32'd5);
    chk("r_s1_rdata", 32'(s1_rdata_o), 32'h70);
    chk("r_s0_rvalid", 32'(s0_rvalid_o), 32'd0);
    s1_rready_i = 0;
    #1; chk("r_rready_low", 32'(m_rready_o), 32'd0);
    s1_rready_i = 1;
    tick();
    idle(); tick();

    // throttle requester 0 at MAX_OUTSTANDING
    do_reset();
    for (int k = 0; k < MAXO; k++) issue0(3'(k), 1'b1);
    s1_arvalid_i = 1; s1_arid_i = 3'd6;
    #1;
    chk("thr_rdy0", 32'(s0_arready_o), 32'd0);
    chk("thr_rdy1", 32'(s1_arready_o), 32'd1);
    tick();
    s1_arvalid_i = 0;
    m_rvalid_i = 1; m_rid_i = 4'h0; s0_rready_i = 1;
    #1; chk("thr_still_full", 32'(s0_arready_o), 32'd0);
    tick();
    m_rvalid_i = 0;
    #1; chk("thr_freed", 32'(s0_arready_o), 32'd1);
    tick();
    idle(); tick();

    // simultaneous accept and R for requester 0 at count 2
    do_reset();
    issue0(3'd1, 1'b1);
    issue0(3'd2, 1'b1);
    m_rvalid_i = 1; m_rid_i = 4'h1;
    issue0(3'd3, 1'b1);
    m_rvalid_i = 0;
    issue0(3'd4, 1'b1);
    issue0(3'd5, 1'b1);
    issue0(3'd6, 1'b0);

    // async reset while an AR is held
    idle(); tick();
    for (int k = 0; k < 8 && infl.size() > 0; k++) begin
      m_rvalid_i = 1; m_rid_i = infl[0];
      tick();
    end
    idle();
    m_arready_i = 0;
    issue0(3'd7, 1'b1);
    s0_arvalid_i = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_arvalid", 32'(m_arvalid_o), 32'd0);
    chk("async_rst_arid", 32'(m_arid_o), 32'd0);
    tick(); tick();
    rst_n = 1;
    idle();
    for (int k = 0; k < MAXO; k++) issue0(3'(k), 1'b1);
    issue0(3'd0, 1'b0);
    idle(); tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      s0_arvalid_i = ($urandom_range(0, 99) < 60);
      s1_arvalid_i = ($urandom_range(0, 99) < 60);
      s0_arid_i    = 3'($urandom_range(0, 7));
      s1_arid_i    = 3'($urandom_range(0, 7));
      m_arready_i  = ($urandom_range(0, 99) < 70);
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        m_rvalid_i = 1;
        m_rid_i    = infl[$urandom_range(0, infl.size() - 1)];
      end else begin
        m_rvalid_i = 0;
        m_rid_i    = 4'($urandom_range(0, 15));
      end
      m_rdata_i   = 8'($urandom);
      s0_rready_i = ($urandom_range(0, 3) != 0);
      s1_rready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
